// File: rtl/bram_arb_pkg.sv
// Shared types and constants for the BRAM arbiter.
// Contents:
//   resp_sel_t  - owner of the response that is due in the next cycle
//   WAIT_CNT_W  - width of the IF anti-starvation counter
// Optional feature macro used by bram_arbiter: BRAM_ARB_RR_EN
package bram_arb_pkg;

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_IF   = 2'd1,
    RESP_DA   = 2'd2
  } resp_sel_t;

  localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/bram_arb_pick.sv
// Pure combinational two-way grant selection.
// Ports:
//   if_req, da_req - requests already qualified by the caller
//   prio_if        - IF wins a conflict (round-robin turn)
//   force_if       - IF wins a conflict (anti-starvation)
//   if_win, da_win - one-hot-or-zero grant pair
module bram_arb_pick (
  input  logic if_req,
  input  logic da_req,
  input  logic prio_if,
  input  logic force_if,
  output logic if_win,
  output logic da_win
);

  always_comb begin
    if_win = if_req & (~da_req | prio_if | force_if);
    da_win = da_req & ~if_win;
  end

endmodule

// File: rtl/bram_arbiter.sv
// Shares one single-port synchronous BRAM between an instruction-fetch (IF)
// and a data-access (DA) requester. One request per cycle is forwarded to
// the RAM; the registered read data is routed back to its owner one cycle
// later.
// Ports:
//   clk, reset                      - clock, synchronous active-high reset
//   if_req/if_addr/if_gnt           - IF request handshake
//   if_rvalid/if_rdata              - IF response
//   da_req/da_we/da_addr/da_wdata   - DA request (da_we == 0 means read)
//   da_gnt, da_rvalid/da_rdata      - DA grant and response
//   ram_en/ram_we/ram_addr/ram_wdata/ram_rdata - RAM side
// Build option: BRAM_ARB_RR_EN selects round-robin arbitration instead of
// fixed DA priority with MAX_WAIT anti-starvation.
module bram_arbiter
  import bram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic                    if_gnt,
  output logic                    if_rvalid,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  input  logic                    da_req,
  input  logic [DATA_WIDTH/8-1:0] da_we,
  input  logic [ADDR_WIDTH-1:0]   da_addr,
  input  logic [DATA_WIDTH-1:0]   da_wdata,
  output logic                    da_gnt,
  output logic                    da_rvalid,
  output logic [DATA_WIDTH-1:0]   da_rdata,
  output logic                    ram_en,
  output logic [DATA_WIDTH/8-1:0] ram_we,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic [DATA_WIDTH-1:0]   ram_wdata,
  input  logic [DATA_WIDTH-1:0]   ram_rdata
);

  logic      rst_d;
  logic      hold_off;
  logic      prio_if;
  logic      force_if;
  logic      if_win;
  logic      da_win;
  resp_sel_t resp_sel;

  // Grants are suppressed in the reset cycle and the one after it.
  always_ff @(posedge clk) begin
    rst_d <= reset;
  end

  assign hold_off = reset | rst_d;

  bram_arb_pick u_pick (
    .if_req   (if_req & ~hold_off),
    .da_req   (da_req & ~hold_off),
    .prio_if  (prio_if),
    .force_if (force_if),
    .if_win   (if_win),
    .da_win   (da_win)
  );

  assign if_gnt = if_win;
  assign da_gnt = da_win;

`ifdef BRAM_ARB_RR_EN
  // last_da set: DA was granted most recently, so IF wins the next conflict.
  logic last_da;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_da <= 1'b1;
    end else if (if_win) begin
      last_da <= 1'b0;
    end else if (da_win) begin
      last_da <= 1'b1;
    end
  end

  assign prio_if  = last_da;
  assign force_if = 1'b0;
`else
  localparam logic [WAIT_CNT_W-1:0] WAIT_LIMIT = WAIT_CNT_W'(MAX_WAIT);

  logic [WAIT_CNT_W-1:0] wait_cnt;

  // Counts cycles IF is refused; saturates so the force stays up until IF wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (!if_req || if_win) begin
      wait_cnt <= '0;
    end else if (wait_cnt != WAIT_LIMIT) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign prio_if  = 1'b0;
  assign force_if = (wait_cnt == WAIT_LIMIT);
`endif

  always_comb begin
    ram_en    = if_win | da_win;
    ram_we    = '0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (da_win) begin
      ram_we    = da_we;
      ram_addr  = da_addr;
      ram_wdata = da_wdata;
    end else if (if_win) begin
      ram_addr = if_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      resp_sel <= RESP_NONE;
    end else if (if_win) begin
      resp_sel <= RESP_IF;
    end else if (da_win) begin
      resp_sel <= RESP_DA;
    end else begin
      resp_sel <= RESP_NONE;
    end
  end

  // Gating with reset drops a response whose grant preceded the reset cycle.
  assign if_rvalid = (resp_sel == RESP_IF) & ~reset;
  assign da_rvalid = (resp_sel == RESP_DA) & ~reset;
  assign if_rdata  = ram_rdata;
  assign da_rdata  = ram_rdata;

endmodule
